// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter: programmable terminal count, wrap or saturate,
// enable prescaler, synchronous clear/load and wrap/overflow status flags.
module mod_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             overflow_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             terminal,
  output logic             wrap,
  output logic             overflow
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PS_ONE  = PW'(1);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLEAR
  } op_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic             step_fire;
  logic             at_top;
  logic             at_bottom;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  op_e              op;

  assign at_top       = (count_q == MAX_C);
  assign at_bottom    = (count_q == '0);
  assign terminal     = (up_down & at_top) | (~up_down & at_bottom);
  assign step_fire    = enable & (presc_q == PS_LAST);
  assign load_clamped = (load_value > MAX_C) ? MAX_C : load_value;

  always_comb begin
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (step_fire) begin
      op = OP_STEP;
    end
  end

  // A boundary step is only real when the step is not pre-empted by clear/load.
  assign boundary = (op == OP_STEP) & terminal;

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    case (op)
      OP_CLEAR: begin
        count_d = '0;
        presc_d = '0;
      end
      OP_LOAD: begin
        count_d = load_clamped;
        presc_d = '0;
      end
      OP_STEP: begin
        presc_d = '0;
        if (up_down) begin
          if (at_top) begin
            count_d = SATURATE ? count_q : '0;
          end else begin
            count_d = count_q + ONE_C;
          end
        end else begin
          if (at_bottom) begin
            count_d = SATURATE ? count_q : MAX_C;
          end else begin
            count_d = count_q - ONE_C;
          end
        end
      end
      default: begin
        if (enable) begin
          presc_d = presc_q + PS_ONE;
        end
      end
    endcase

    // Set has priority over a same-edge clear request.
    if (boundary) begin
      wrap_d = 1'b1;
      ovf_d  = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out = count_q;
  assign wrap      = wrap_q;
  assign overflow  = ovf_q;

endmodule
